// File: rtl/timer_apb_param.sv
`default_nettype none
//==============================================================================
//  Module   : timer_apb_param
//  Purpose  : APB-programmable CNT_W-bit up/down timer with compare match,
//             optional auto-reload, per-source interrupt enables and a
//             readable live count. Zero-wait-state APB slave.
//  Ports    : pclk/presetn          - clock, asynchronous active-low reset
//             psel/penable/pwrite   - APB control
//             paddr/pwdata/prdata   - APB address, write data, read data
//             pready/pslverr        - always ready, error on unmapped access
//             ovf_int/udf_int/cmp_int - flag AND enable interrupt outputs
//  Register map:
//             0x00 TDR  rw  reload/load value
//             0x01 TCR  rw  [7]load [6]arl [5]dw [4]en [3]cie [2]fie [1:0]cks
//             0x02 TSR  w1c [0]ovf [1]udf [2]cmp
//             0x03 TCMP rw  compare value (resets to all ones)
//             0x04 TCNT ro  live count
//  Revision : 1.0 - initial release
//==============================================================================
module timer_apb_param #(
   parameter int CNT_W  = 8,
   parameter int ADDR_W = 8
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [CNT_W-1:0]  pwdata,
   output logic [CNT_W-1:0]  prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              ovf_int,
   output logic              udf_int,
   output logic              cmp_int
);

   localparam logic [ADDR_W-1:0] ADDR_TDR  = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_TCR  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_TSR  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_TCMP = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] ADDR_TCNT = ADDR_W'(4);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   logic [CNT_W-1:0] tdr;
   logic [CNT_W-1:0] tcmp;
   logic [CNT_W-1:0] tcnt;
   logic [CNT_W-1:0] cnt_next;
   logic [7:0]       tcr;
   logic [2:0]       tsr;
   logic [2:0]       tsr_set;
   logic [2:0]       tsr_clr;
   logic [3:0]       presc;
   logic [3:0]       presc_mask;
   logic             tick;
   logic             wr_en;
   logic             mapped;

   // Control fields
   logic       load, arl, dw, en, cie, fie;
   logic [1:0] cks;
   assign load = tcr[7];
   assign arl  = tcr[6];
   assign dw   = tcr[5];
   assign en   = tcr[4];
   assign cie  = tcr[3];
   assign fie  = tcr[2];
   assign cks  = tcr[1:0];

   assign wr_en  = psel & penable & pwrite;
   assign mapped = (paddr <= ADDR_TCNT);

   // Tick when the low (cks+1) prescaler bits are all ones.
   always_comb begin
      presc_mask = 4'hF;
      case (cks)
         2'd0:    presc_mask = 4'h1;
         2'd1:    presc_mask = 4'h3;
         2'd2:    presc_mask = 4'h7;
         default: presc_mask = 4'hF;
      endcase
   end
   assign tick = ((presc & presc_mask) == presc_mask);

   // Counter next-state and hardware flag sets. All decisions use the
   // registered TCR/TDR, so a same-cycle APB write only takes effect next cycle.
   always_comb begin
      cnt_next = tcnt;
      tsr_set  = 3'b000;
      if (load) begin
         cnt_next = tdr;
      end else if (en && tick) begin
         if (!dw) begin
            if (tcnt == CNT_MAX) begin
               cnt_next   = arl ? tdr : '0;
               tsr_set[0] = 1'b1;
            end else begin
               cnt_next = tcnt + CNT_W'(1);
            end
         end else begin
            if (tcnt == '0) begin
               cnt_next   = arl ? tdr : CNT_MAX;
               tsr_set[1] = 1'b1;
            end else begin
               cnt_next = tcnt - CNT_W'(1);
            end
         end
         if (cnt_next == tcmp) begin
            tsr_set[2] = 1'b1;
         end
      end
   end

   assign tsr_clr = (wr_en && paddr == ADDR_TSR) ? pwdata[2:0] : 3'b000;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         presc <= 4'h0;
         tdr   <= '0;
         tcr   <= 8'h00;
         tsr   <= 3'b000;
         tcmp  <= CNT_MAX;
         tcnt  <= '0;
      end else begin
         presc <= presc + 4'h1;
         tcnt  <= cnt_next;
         // Hardware set is OR'd in after the clear so it wins a collision.
         tsr   <= (tsr & ~tsr_clr) | tsr_set;
         if (wr_en) begin
            if (paddr == ADDR_TDR)  tdr  <= pwdata;
            if (paddr == ADDR_TCR)  tcr  <= pwdata[7:0];
            if (paddr == ADDR_TCMP) tcmp <= pwdata;
         end
      end
   end

   always_comb begin
      prdata = '0;
      case (paddr)
         ADDR_TDR:  prdata = tdr;
         ADDR_TCR:  prdata = CNT_W'(tcr);
         ADDR_TSR:  prdata = CNT_W'(tsr);
         ADDR_TCMP: prdata = tcmp;
         ADDR_TCNT: prdata = tcnt;
         default:   prdata = '0;
      endcase
   end

   assign pready  = 1'b1;
   assign pslverr = psel & penable & ~mapped;

   assign ovf_int = tsr[0] & fie;
   assign udf_int = tsr[1] & fie;
   assign cmp_int = tsr[2] & cie;

endmodule
`default_nettype wire

// File: tb/tb_timer_apb_param.sv
`default_nettype none
//==============================================================================
//  Module   : tb_timer_apb_param
//  Purpose  : Directed self-checking bench for timer_apb_param. One 8-bit and
//             one 16-bit instance share the APB bus; each has its own psel.
//  Revision : 1.0 - initial release
//==============================================================================
module tb_timer_apb_param;

   logic        pclk    = 1'b0;
   logic        presetn = 1'b0;
   logic        psel8   = 1'b0;
   logic        psel16  = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite  = 1'b0;
   logic [7:0]  paddr   = 8'h00;
   logic [15:0] pwdata  = 16'h0000;

   logic [7:0]  prdata8;
   logic [15:0] prdata16;
   logic        pready8, pslverr8, ovf8, udf8, cmp8;
   logic        pready16, pslverr16, ovf16, udf16, cmp16;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 pclk = ~pclk;

   // Mirrors the free-running prescaler: edges since reset release.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   timer_apb_param #(.CNT_W(8), .ADDR_W(8)) dut8 (
      .pclk(pclk), .presetn(presetn), .psel(psel8), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata[7:0]), .prdata(prdata8),
      .pready(pready8), .pslverr(pslverr8), .ovf_int(ovf8), .udf_int(udf8),
      .cmp_int(cmp8));

   timer_apb_param #(.CNT_W(16), .ADDR_W(8)) dut16 (
      .pclk(pclk), .presetn(presetn), .psel(psel16), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata16),
      .pready(pready16), .pslverr(pslverr16), .ovf_int(ovf16), .udf_int(udf16),
      .cmp_int(cmp16));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Write: setup on the next negedge, access one cycle later; commits on the
   // posedge in between, returns on the negedge after the commit.
   task automatic wr(input bit which, input logic [7:0] a, input logic [15:0] d);
      @(negedge pclk);
      psel8 = !which; psel16 = which; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      psel8 = 1'b0; psel16 = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic rd(input bit which, input logic [7:0] a, output logic [31:0] d);
      paddr = a;
      #1;
      d = which ? 32'(prdata16) : 32'(prdata8);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [31:0] v;
      int  n;
      bit  found;

      repeat (3) @(negedge pclk);
      presetn = 1'b1;

      // Reset state
      rd(1, 8'h00, d); chk("rst_tdr16", d, 32'h0);
      rd(1, 8'h03, d); chk("rst_tcmp16", d, 32'hFFFF);
      rd(0, 8'h03, d); chk("rst_tcmp8", d, 32'hFF);
      rd(0, 8'h04, d); chk("rst_tcnt8", d, 32'h0);
      chk("rst_pready", {31'b0, pready8 & pready16}, 32'h1);

      // T1: down count from 10, cks=1, underflow to max (compare also hits max)
      wr(0, 8'h00, 16'h000A);
      wr(0, 8'h01, 16'h0080);
      wr(0, 8'h01, 16'h0031);
      paddr = 8'h02; found = 0; n = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge pclk); #1; n++;
         if (prdata8[1]) found = 1;
      end
      chk("t1_udf_seen", 32'(found), 32'h1);
      chk("t1_udf_latency", 32'(n >= 41 && n <= 44), 32'h1);
      rd(0, 8'h04, d); chk("t1_tcnt", d, 32'hFF);
      rd(0, 8'h02, d); chk("t1_tsr", d, 32'h6);
      chk("t1_udf_int", {31'b0, udf8}, 32'h0);

      // T2: 16-bit up count with auto-reload from 0xFFFD
      wr(1, 8'h00, 16'hFFFD);
      wr(1, 8'h01, 16'h0080);
      wr(1, 8'h01, 16'h0054);
      found = 0; n = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge pclk); n++;
         if (ovf16) found = 1;
      end
      chk("t2_ovf_seen", 32'(found), 32'h1);
      chk("t2_ovf_latency", 32'(n == 5 || n == 6), 32'h1);
      rd(1, 8'h04, d); chk("t2_tcnt_reload", d, 32'hFFFD);
      rd(1, 8'h02, d); chk("t2_tsr", d, 32'h5);
      wr(1, 8'h01, 16'h0044);
      chk("t2_ovf_int_held", {31'b0, ovf16}, 32'h1);
      wr(1, 8'h02, 16'h0001);
      chk("t2_ovf_int_clr", {31'b0, ovf16}, 32'h0);
      rd(1, 8'h02, d); chk("t2_tsr_cmp_kept", d, 32'h4);

      // T3: compare match while counting, not on load
      wr(0, 8'h01, 16'h0000);
      wr(0, 8'h02, 16'h0007);
      rd(0, 8'h02, d); chk("t3_tsr_cleared", d, 32'h0);
      wr(0, 8'h03, 16'h0005);
      wr(0, 8'h00, 16'h0005);
      wr(0, 8'h01, 16'h0088);
      repeat (3) @(negedge pclk);
      rd(0, 8'h04, d); chk("t3_load_val", d, 32'h5);
      rd(0, 8'h02, d); chk("t3_no_cmp_on_load", d, 32'h0);
      chk("t3_cmp_int_load", {31'b0, cmp8}, 32'h0);
      wr(0, 8'h00, 16'h0000);
      repeat (2) @(negedge pclk);
      wr(0, 8'h01, 16'h0018);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge pclk);
         if (cmp8) found = 1;
      end
      chk("t3_cmp_seen", 32'(found), 32'h1);
      rd(0, 8'h04, d); chk("t3_tcnt_at_cmp", d, 32'h5);
      rd(0, 8'h02, d); chk("t3_tsr", d, 32'h4);

      // T4: ovf sets on every tick (TDR=max, arl); w1c off-tick vs on-tick
      wr(1, 8'h00, 16'hFFFF);
      wr(1, 8'h01, 16'h00C4);
      wr(1, 8'h01, 16'h0054);
      repeat (4) @(negedge pclk);
      chk("t4_ovf_running", {31'b0, ovf16}, 32'h1);
      @(negedge pclk);
      if (cyc[0] == 1'b1) @(negedge pclk);
      wr(1, 8'h02, 16'h0001);
      rd(1, 8'h02, d); chk("t4_w1c_off_tick", {31'b0, d[0]}, 32'h0);
      @(negedge pclk);
      if (cyc[0] == 1'b0) @(negedge pclk);
      wr(1, 8'h02, 16'h0001);
      rd(1, 8'h02, d); chk("t4_set_wins", {31'b0, d[0]}, 32'h1);
      @(negedge pclk);
      psel16 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h07;
      #1;
      chk("t4_unmapped_prdata", 32'(prdata16), 32'h0);
      chk("t4_unmapped_pslverr", {31'b0, pslverr16}, 32'h1);
      paddr = 8'h02;
      #1;
      chk("t4_mapped_pslverr", {31'b0, pslverr16}, 32'h0);
      psel16 = 1'b0; penable = 1'b0;

      // T5: asynchronous reset mid-run
      chk("t5_pre_cmp_int", {31'b0, cmp8}, 32'h1);
      @(negedge pclk);
      #2 presetn = 1'b0;
      #1;
      chk("t5_ints", {29'b0, cmp8, ovf16, udf8}, 32'h0);
      rd(0, 8'h00, d); chk("t5_tdr", d, 32'h0);
      rd(0, 8'h01, d); chk("t5_tcr", d, 32'h0);
      rd(0, 8'h02, d); chk("t5_tsr", d, 32'h0);
      rd(0, 8'h03, d); chk("t5_tcmp", d, 32'hFF);
      rd(0, 8'h04, d); chk("t5_tcnt", d, 32'h0);
      rd(1, 8'h03, d); chk("t5_tcmp16", d, 32'hFFFF);
      @(negedge pclk);
      presetn = 1'b1;

      // T6: disable freezes count, re-enable resumes
      wr(0, 8'h00, 16'h0020);
      wr(0, 8'h01, 16'h0080);
      wr(0, 8'h01, 16'h0010);
      repeat (10) @(negedge pclk);
      wr(0, 8'h01, 16'h0000);
      rd(0, 8'h04, v);
      chk("t6_counted", 32'(v != 32'h20), 32'h1);
      repeat (20) @(negedge pclk);
      rd(0, 8'h04, d); chk("t6_hold", d, v);
      wr(0, 8'h01, 16'h0010);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge pclk);
         rd(0, 8'h04, d);
         if (d != v) found = 1;
      end
      chk("t6_resumed", 32'(found), 32'h1);
      chk("t6_resume_val", d, (v + 32'h1) & 32'hFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
